// File: rtl/amm_config_master_pkg.sv
// -----------------------------------------------------------------------------
// amm_config_master_pkg
// Shared definitions for the Avalon-MM configuration master:
//   - sequencer state encoding
//   - register map of the key-matching slave (control word + pattern words)
//   - control register bit positions
//   - default bus address width used by avalon_mm_if
// -----------------------------------------------------------------------------
package amm_config_master_pkg;

    localparam int AMM_ADDR_WIDTH = 8;

    // Slave register map
    localparam int CTRL_ADDR     = 0;
    localparam int PAT_BASE_ADDR = 1;

    // Control register fields
    localparam int CTRL_EN_BIT = 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DIS  = 3'd1,
        WR_PAT  = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        WR_EN   = 3'd5,
        FIN     = 3'd6
    } state_t;

endpackage

// File: rtl/avalon_mm_if.sv
// -----------------------------------------------------------------------------
// avalon_mm_if
// Minimal Avalon-MM bundle (no byteenable / burst) used between the
// configuration master and the register slave.
//   address        master -> slave   word address
//   write          master -> slave   write request
//   writedata      master -> slave   write data
//   read           master -> slave   read request
//   readdata       slave  -> master  read data
//   readdatavalid  slave  -> master  readdata qualifier
//   waitrequest    slave  -> master  stall; request must be held while high
// -----------------------------------------------------------------------------
interface avalon_mm_if
    import amm_config_master_pkg::*;
#(
    parameter int ADDR_WIDTH = AMM_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0] address;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  read;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (
        output address, write, writedata, read,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, readdatavalid, waitrequest
    );

endinterface

// File: rtl/pattern_packer.sv
// -----------------------------------------------------------------------------
// pattern_packer
// Combinational mapping of the key pattern onto slave register words, indexed
// by register address. The same word table feeds the write path and the
// read-back compare, so both always agree on the layout.
//   pattern_i  [0:PAT_SIZE-1]              key pattern, bit 0 first
//   words_o    [REG_DEPTH][REG_WIDTH]      word per address (address 0 = 0)
//
// Chunk j (pattern bits j*REG_WIDTH upward) lands at address REG_DEPTH-1-j;
// symbol i of a chunk occupies word bits [REG_WIDTH-(i+1)*BIT_PER_SYMB +:
// BIT_PER_SYMB], i.e. the first symbol is in the most significant byte.
// -----------------------------------------------------------------------------
module pattern_packer
    import amm_config_master_pkg::*;
#(
    parameter int REG_WIDTH    = 32,
    parameter int REG_DEPTH    = 4,
    parameter int PAT_WIDTH    = REG_DEPTH - 1,
    parameter int PAT_SIZE     = PAT_WIDTH * REG_WIDTH,
    parameter int BIT_PER_SYMB = 8
) (
    input  logic [0:PAT_SIZE-1]                  pattern_i,
    output logic [REG_DEPTH-1:0][REG_WIDTH-1:0]  words_o
);

    localparam int SYMB_PER_WORD = REG_WIDTH / BIT_PER_SYMB;

    for (genvar a = 0; a < REG_DEPTH; a++) begin : g_addr
        if (a >= REG_DEPTH - PAT_WIDTH) begin : g_pat
            localparam int J = REG_DEPTH - 1 - a;
            for (genvar i = 0; i < SYMB_PER_WORD; i++) begin : g_symb
                assign words_o[a][REG_WIDTH-(i+1)*BIT_PER_SYMB +: BIT_PER_SYMB] =
                    pattern_i[J*REG_WIDTH + i*BIT_PER_SYMB +: BIT_PER_SYMB];
            end
            // Leftover low bits when REG_WIDTH is not a whole number of symbols
            if (SYMB_PER_WORD * BIT_PER_SYMB < REG_WIDTH) begin : g_pad
                assign words_o[a][REG_WIDTH-SYMB_PER_WORD*BIT_PER_SYMB-1:0] = '0;
            end
        end else begin : g_none
            assign words_o[a] = '0;
        end
    end

endmodule

// File: rtl/amm_config_master.sv
// -----------------------------------------------------------------------------
// amm_config_master
// Loads a key pattern into an Avalon-MM register slave: disables matching,
// writes the pattern words, reads them back for verification and finally
// re-enables matching with the requested enable value.
//
// Ports
//   clk_i          sole clock
//   srst_n_i       synchronous active-low reset
//   start_i        one-cycle start request (ignored while busy)
//   enable_i       value for control bit 0 written at the end of a sequence
//   pattern_i      key pattern, latched on start
//   amm_master_if  Avalon-MM master port
//   busy_o         high in every state except IDLE
//   done_o         one-cycle pulse on fault-free completion
//   error_o        sticky read-back mismatch / timeout flag, cleared on start
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start_i
// WR_DIS  | write 0 to control register (matching off during update)
// WR_PAT  | write pattern words, addresses 1..PAT_WIDTH ascending
// RD_REQ  | issue read of current pattern address, hold until accepted
// RD_WAIT | read accepted, waiting for readdatavalid (bounded by timer)
// WR_EN   | write latched enable to control register
// FIN     | pulse done_o when error-free, then back to IDLE
// -----------------------------------------------------------------------------
module amm_config_master
    import amm_config_master_pkg::*;
#(
    parameter int REG_WIDTH    = 32,
    parameter int REG_DEPTH    = 4,
    parameter int PAT_WIDTH    = REG_DEPTH - 1,
    parameter int PAT_SIZE     = PAT_WIDTH * REG_WIDTH,
    parameter int BIT_PER_SYMB = 8,
    parameter int RD_TIMEOUT   = 16
) (
    input  logic                clk_i,
    input  logic                srst_n_i,
    input  logic                start_i,
    input  logic                enable_i,
    input  logic [0:PAT_SIZE-1] pattern_i,
    avalon_mm_if.master         amm_master_if,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o
);

    localparam int IDX_W = $clog2(REG_DEPTH);
    localparam int TMR_W = $clog2(RD_TIMEOUT + 1);

    state_t                            state_q, state_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [TMR_W-1:0]                  timer_q, timer_d;
    logic                              error_q, error_d;
    logic [0:PAT_SIZE-1]               pattern_q;
    logic                              enable_q;
    logic                              latch;

    logic [REG_DEPTH-1:0][REG_WIDTH-1:0] words;
    logic                              last_idx;
    logic                              rd_match;

    logic                              rd;
    logic                              wr;
    logic [AMM_ADDR_WIDTH-1:0]         addr;
    logic [REG_WIDTH-1:0]              wdata;

    pattern_packer #(
        .REG_WIDTH    (REG_WIDTH),
        .REG_DEPTH    (REG_DEPTH),
        .PAT_WIDTH    (PAT_WIDTH),
        .PAT_SIZE     (PAT_SIZE),
        .BIT_PER_SYMB (BIT_PER_SYMB)
    ) u_pattern_packer (
        .pattern_i (pattern_q),
        .words_o   (words)
    );

    assign last_idx = (idx_q == IDX_W'(PAT_WIDTH));
    assign rd_match = (amm_master_if.readdata == words[idx_q]);

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            timer_q   <= '0;
            error_q   <= 1'b0;
            pattern_q <= '0;
            enable_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            error_q <= error_d;
            if (latch) begin
                pattern_q <= pattern_i;
                enable_q  <= enable_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        error_d = error_q;
        latch   = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        wdata   = '0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    latch   = 1'b1;
                    error_d = 1'b0;
                    state_d = WR_DIS;
                end
            end

            WR_DIS: begin
                wr   = 1'b1;
                addr = AMM_ADDR_WIDTH'(CTRL_ADDR);
                if (!amm_master_if.waitrequest) begin
                    idx_d   = IDX_W'(PAT_BASE_ADDR);
                    state_d = WR_PAT;
                end
            end

            WR_PAT: begin
                wr    = 1'b1;
                addr  = AMM_ADDR_WIDTH'(idx_q);
                wdata = words[idx_q];
                if (!amm_master_if.waitrequest) begin
                    if (last_idx) begin
                        idx_d   = IDX_W'(PAT_BASE_ADDR);
                        state_d = RD_REQ;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            RD_REQ: begin
                rd   = 1'b1;
                addr = AMM_ADDR_WIDTH'(idx_q);
                if (!amm_master_if.waitrequest) begin
                    // Zero-latency slave: data can arrive with the accept
                    if (amm_master_if.readdatavalid) begin
                        if (!rd_match) begin
                            error_d = 1'b1;
                            state_d = FIN;
                        end else if (last_idx) begin
                            state_d = WR_EN;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = RD_REQ;
                        end
                    end else begin
                        timer_d = TMR_W'(RD_TIMEOUT - 1);
                        state_d = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                addr = AMM_ADDR_WIDTH'(idx_q);
                if (amm_master_if.readdatavalid) begin
                    if (!rd_match) begin
                        error_d = 1'b1;
                        state_d = FIN;
                    end else if (last_idx) begin
                        state_d = WR_EN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end else if (timer_q == '0) begin
                    error_d = 1'b1;
                    state_d = FIN;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            WR_EN: begin
                wr                 = 1'b1;
                addr               = AMM_ADDR_WIDTH'(CTRL_ADDR);
                wdata[CTRL_EN_BIT] = enable_q;
                if (!amm_master_if.waitrequest) begin
                    state_d = FIN;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign amm_master_if.read      = rd;
    assign amm_master_if.write     = wr;
    assign amm_master_if.address   = addr;
    assign amm_master_if.writedata = wdata;

    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == FIN) && !error_q;
    assign error_o = error_q;

endmodule

// File: tb/tb_amm_config_master.sv
module tb_amm_config_master;
    import amm_config_master_pkg::*;

    localparam int RW = 32;
    localparam int RD = 4;
    localparam int PW = 3;
    localparam int PS = PW * RW;

    localparam logic [95:0] PA = 96'h000102030405060708090A0B;
    localparam logic [95:0] PB = 96'hDEADBEEF0123456789ABCDEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            srst_n_i  = 1'b0;
    logic            start_i   = 1'b0;
    logic            enable_i  = 1'b0;
    logic [0:PS-1]   pattern_i = '0;
    logic            busy_o;
    logic            done_o;
    logic            error_o;

    avalon_mm_if #(.ADDR_WIDTH(AMM_ADDR_WIDTH), .DATA_WIDTH(RW)) bus ();

    amm_config_master #(
        .REG_WIDTH    (RW),
        .REG_DEPTH    (RD),
        .PAT_WIDTH    (PW),
        .PAT_SIZE     (PS),
        .BIT_PER_SYMB (8),
        .RD_TIMEOUT   (16)
    ) dut (
        .clk_i         (clk),
        .srst_n_i      (srst_n_i),
        .start_i       (start_i),
        .enable_i      (enable_i),
        .pattern_i     (pattern_i),
        .amm_master_if (bus),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o)
    );

    // ---------------- register-file slave model ----------------
    int          wait_n  = 0;
    bit          corrupt = 1'b0;
    bit          nordv   = 1'b0;
    int          wcnt    = 0;
    logic [RW-1:0] sregs [RD];

    assign bus.waitrequest   = (bus.read || bus.write) && (wcnt < wait_n);
    assign bus.readdatavalid = bus.read && !bus.waitrequest && !nordv;
    assign bus.readdata      = sregs[bus.address[1:0]] ^
                               ((corrupt && bus.address == 8'd2) ? 32'h1 : 32'h0);

    always @(posedge clk) begin
        if (!srst_n_i) begin
            wcnt <= 0;
            for (int k = 0; k < RD; k++) sregs[k] <= '0;
        end else begin
            if (bus.read || bus.write) wcnt <= bus.waitrequest ? wcnt + 1 : 0;
            else                       wcnt <= 0;
            if (bus.write && !bus.waitrequest) sregs[bus.address[1:0]] <= bus.writedata;
        end
    end

    // ---------------- monitor ----------------
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          start_cyc = 0;
    int          log_n = 0;
    bit          log_w [256];
    logic [7:0]  log_a [256];
    logic [31:0] log_d [256];
    int          done_n = 0, done_cyc = -1, err_cyc = -1;
    int          overlap_n = 0, hold_n = 0;
    bit          pend = 1'b0, err_prev = 1'b0;
    logic [41:0] prev_bus = '0;

    always @(negedge clk) begin
        if (srst_n_i) begin
            if (bus.read && bus.write) overlap_n++;
            if (pend && ({bus.write, bus.read, bus.address, bus.writedata} != prev_bus)) hold_n++;
            pend     = (bus.read || bus.write) && bus.waitrequest;
            prev_bus = {bus.write, bus.read, bus.address, bus.writedata};
            if ((bus.read || bus.write) && !bus.waitrequest && log_n < 256) begin
                log_w[log_n] = bus.write;
                log_a[log_n] = bus.address;
                log_d[log_n] = bus.write ? bus.writedata : 32'h0;
                log_n++;
            end
            if (done_o) begin
                done_n++;
                done_cyc = cyc - start_cyc;
            end
            if (error_o && !err_prev) err_cyc = cyc - start_cyc;
            err_prev = error_o;
        end else begin
            pend     = 1'b0;
            err_prev = 1'b0;
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Start request in cycle 0; returns at the falling edge of cycle 1.
    // Inputs are scrambled afterwards so only the latched copy can be used.
    task automatic pulse_start(input logic [95:0] pat, input logic en);
        @(negedge clk);
        pattern_i = pat;
        enable_i  = en;
        start_cyc = cyc;
        start_i   = 1'b1;
        @(negedge clk);
        start_i   = 1'b0;
        pattern_i = ~pat;
        enable_i  = ~en;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy_o, 1'b0);
        @(negedge clk);
    endtask

    function automatic logic [40:0] log_entry(input int k);
        if (k < log_n) return {log_w[k], log_a[k], log_d[k]};
        return '1;
    endfunction

    typedef struct {
        logic [95:0] pat;
        logic        en;
        int          wt;
        bit          corrupt;
        bit          nordv;
        logic [31:0] w1, w2, w3;
        int          n_reads;
        bit          final_wr;
        bit          exp_err;
        int          exp_cyc;   // done cycle, or first error cycle when exp_err
    } vec_t;

    vec_t vecs [6];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : test
        int base_log, base_done, base_ov, base_hold;
        int n_exp;
        bit          ew [16];
        logic [7:0]  ea [16];
        logic [31:0] ed [16];

        vecs[0] = '{PA, 1'b1, 0, 1'b0, 1'b0, 32'h08090A0B, 32'h04050607, 32'h00010203, 3, 1'b1, 1'b0, 9};
        vecs[1] = '{PB, 1'b0, 0, 1'b0, 1'b0, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF, 3, 1'b1, 1'b0, 9};
        vecs[2] = '{PA, 1'b1, 3, 1'b0, 1'b0, 32'h08090A0B, 32'h04050607, 32'h00010203, 3, 1'b1, 1'b0, 33};
        vecs[3] = '{PA, 1'b1, 0, 1'b1, 1'b0, 32'h08090A0B, 32'h04050607, 32'h00010203, 2, 1'b0, 1'b1, 7};
        vecs[4] = '{PB, 1'b1, 0, 1'b0, 1'b1, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF, 1, 1'b0, 1'b1, 22};
        vecs[5] = '{PB, 1'b1, 1, 1'b0, 1'b0, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF, 3, 1'b1, 1'b0, 17};

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy_o, done_o, error_o, bus.read, bus.write, bus.address, bus.writedata}, '0);
        srst_n_i = 1'b1;
        repeat (2) @(negedge clk);

        // table-driven sequences
        for (int v = 0; v < 6; v++) begin
            wait_n    = vecs[v].wt;
            corrupt   = vecs[v].corrupt;
            nordv     = vecs[v].nordv;
            base_log  = log_n;
            base_done = done_n;
            base_ov   = overlap_n;
            base_hold = hold_n;

            pulse_start(vecs[v].pat, vecs[v].en);
            wait_idle(300, $sformatf("v%0d_idle_timeout", v));

            n_exp = 0;
            ew[0] = 1'b1; ea[0] = 8'd0; ed[0] = 32'h0;
            ew[1] = 1'b1; ea[1] = 8'd1; ed[1] = vecs[v].w1;
            ew[2] = 1'b1; ea[2] = 8'd2; ed[2] = vecs[v].w2;
            ew[3] = 1'b1; ea[3] = 8'd3; ed[3] = vecs[v].w3;
            n_exp = 4;
            for (int r = 1; r <= vecs[v].n_reads; r++) begin
                ew[n_exp] = 1'b0; ea[n_exp] = 8'(r); ed[n_exp] = 32'h0;
                n_exp++;
            end
            if (vecs[v].final_wr) begin
                ew[n_exp] = 1'b1; ea[n_exp] = 8'd0; ed[n_exp] = {31'b0, vecs[v].en};
                n_exp++;
            end

            chk($sformatf("v%0d_xfer_count", v), log_n - base_log, n_exp);
            for (int i = 0; i < n_exp; i++)
                chk($sformatf("v%0d_xfer%0d", v, i), log_entry(base_log + i), {ew[i], ea[i], ed[i]});

            chk($sformatf("v%0d_done_count", v), done_n - base_done, vecs[v].exp_err ? 0 : 1);
            if (vecs[v].exp_err) chk($sformatf("v%0d_error_cycle", v), err_cyc, vecs[v].exp_cyc);
            else                 chk($sformatf("v%0d_done_cycle", v), done_cyc, vecs[v].exp_cyc);
            chk($sformatf("v%0d_error_o", v), error_o, vecs[v].exp_err);
            chk($sformatf("v%0d_busy_o", v), busy_o, 1'b0);
            chk($sformatf("v%0d_slave_pattern", v), {sregs[3], sregs[2], sregs[1]}, vecs[v].pat);
            chk($sformatf("v%0d_ctrl_reg", v), sregs[0], vecs[v].final_wr ? {31'b0, vecs[v].en} : 32'h0);
            chk($sformatf("v%0d_rd_wr_overlap", v), overlap_n - base_ov, 0);
            chk($sformatf("v%0d_hold_stable", v), hold_n - base_hold, 0);
        end

        // reset in the middle of WR_PAT, then a fresh sequence
        wait_n = 0; corrupt = 1'b0; nordv = 1'b0;
        base_done = done_n;
        pulse_start(PA, 1'b1);
        repeat (2) @(negedge clk);
        chk("rst_in_wr_pat", {busy_o, bus.write, bus.address}, {1'b1, 1'b1, 8'd2});
        srst_n_i = 1'b0;
        @(negedge clk);
        chk("rst_outputs_zero", {busy_o, done_o, error_o, bus.read, bus.write, bus.address, bus.writedata}, '0);
        @(negedge clk);
        srst_n_i = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_no_resume", {busy_o, bus.write, bus.read}, 3'b000);
        chk("rst_no_done", done_n - base_done, 0);
        base_log = log_n;
        pulse_start(PB, 1'b1);
        chk("rst_restart_wr_dis", {busy_o, bus.write, bus.read, bus.address, bus.writedata},
            {1'b1, 1'b1, 1'b0, 8'd0, 32'd0});
        wait_idle(300, "rst_restart_timeout");
        chk("rst_restart_done", done_n - base_done, 1);
        chk("rst_restart_cycle", done_cyc, 9);
        chk("rst_restart_xfers", log_n - base_log, 8);
        chk("rst_restart_pattern", {sregs[3], sregs[2], sregs[1]}, PB);

        // start pulse while busy must be ignored
        base_done = done_n;
        base_log  = log_n;
        pulse_start(PA, 1'b0);
        repeat (3) @(negedge clk);
        pattern_i = PB;
        start_i   = 1'b1;
        @(negedge clk);
        start_i   = 1'b0;
        wait_idle(300, "busy_start_timeout");
        repeat (20) @(negedge clk);
        chk("busy_start_done_count", done_n - base_done, 1);
        chk("busy_start_xfers", log_n - base_log, 8);
        chk("busy_start_cycle", done_cyc, 9);
        chk("busy_start_idle", busy_o, 1'b0);
        chk("busy_start_pattern", {sregs[3], sregs[2], sregs[1]}, PA);
        chk("busy_start_ctrl", sregs[0], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
